// File: rtl/ram_reader_if.sv
// Command, RAM-read and output-stream signals of the RAM reader.
// slave  : the reader's view (takes commands, drives the RAM address and the stream).
// master : the surrounding system's view (issues commands, returns RAM data, sinks the stream).
interface ram_reader_if #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 5
) ();
  // Command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [ADDRWIDTH:0]   cmd_len;

  // Synchronous RAM read port (data returns one clock after the address)
  logic [ADDRWIDTH-1:0] rd_addr;
  logic [DATAWIDTH-1:0] rd_data;

  // Output stream
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  // Status
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, rd_data, out_ready,
    output cmd_ready, rd_addr, out_data, out_valid, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, rd_data, out_ready,
    input  cmd_ready, rd_addr, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/ram_reader.sv
// RAM reader: accepts (start address, length) commands and streams the
// addressed words of a synchronous-read RAM out as a valid/ready stream.
// Reads are issued one per clock while the 2-entry output buffer plus the
// read in flight leave room, so a continuously-ready sink gets 1 word/clk.
module ram_reader #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 5
) (
  input  logic        clk,
  input  logic        reset,
  ram_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Control state
  state_t               state_reg;
  state_t               state_next;

  // Read issue bookkeeping
  logic [ADDRWIDTH-1:0] addr_reg;          // next address to issue
  logic [ADDRWIDTH-1:0] last_addr_reg;     // address most recently presented to the RAM
  logic [ADDRWIDTH:0]   remain_reg;        // reads still to issue for this command
  logic                 inflight_reg;      // a read was issued last cycle; rd_data is valid now
  logic                 inflight_last_reg; // ...and it was the final read of the command

  // Two-entry output buffer
  logic [DATAWIDTH-1:0] buf_data_reg [2];
  logic [1:0]           buf_last_reg;
  logic                 head_reg;
  logic [1:0]           count_reg;
  logic [1:0]           count_next;

  // Combinational control
  logic                 cmd_ready_int;
  logic                 busy_int;
  logic                 cmd_fire;
  logic                 start;
  logic                 issue;
  logic                 issue_last;
  logic                 push;
  logic                 pop;
  logic                 wr_idx;
  logic                 head_last;
  logic [1:0]           occ_eff;
  logic [1:0]           buf_we;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign cmd_fire   = bus.cmd_valid && cmd_ready_int;
  assign start      = cmd_fire && (bus.cmd_len != '0);
  assign issue_last = (remain_reg == {{ADDRWIDTH{1'b0}}, 1'b1});

  // The word returning from the RAM is captured unconditionally; room was
  // reserved for it when the read was issued.
  assign push      = inflight_reg;
  assign pop       = (count_reg != 2'd0) && bus.out_ready;
  assign head_last = buf_last_reg[head_reg];

  // Occupancy as it will stand after this cycle's pop, plus the read already
  // in flight. Counting the pop lets a read be issued in the same cycle a
  // word leaves, which is what keeps the stream at one word per clock.
  assign occ_eff = count_reg + {1'b0, inflight_reg} - {1'b0, pop};

  // Tail slot: head + occupancy, modulo 2. A push never happens when full.
  assign wr_idx = head_reg ^ count_reg[0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // Advance the control state; reset aborts any command in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // IDLE waits for a non-empty command, RUN issues reads, DRAIN empties the
  // buffer until the word tagged last is taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (issue && issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Command acceptance, busy flag and the per-cycle read-issue decision.
  always_comb begin
    cmd_ready_int = 1'b0;
    busy_int      = 1'b1;
    issue         = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_int = 1'b1;
        busy_int      = 1'b0;
      end
      RUN: begin
        issue = (occ_eff < 2'd2);
      end
      DRAIN: begin
        issue = 1'b0;
      end
      default: begin
        cmd_ready_int = 1'b0;
        busy_int      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read issue datapath
  // ---------------------------------------------------------------------------
  // Latch the command on start, then step the address (wrapping naturally at
  // the RAM depth) and the remaining count on every issued read.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg          <= '0;
      last_addr_reg     <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      if (start) begin
        addr_reg   <= bus.cmd_addr;
        remain_reg <= bus.cmd_len;
      end else if (issue) begin
        addr_reg      <= addr_reg + ADDRWIDTH'(1);
        remain_reg    <= remain_reg - {{ADDRWIDTH{1'b0}}, 1'b1};
        last_addr_reg <= addr_reg;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue && issue_last;
    end
  end

  // The RAM sees the new address in the issue cycle itself, so data lands in
  // the buffer two clocks after the command is accepted; otherwise the last
  // issued address is held.
  assign bus.rd_addr = issue ? addr_reg : last_addr_reg;

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < 2; gi++) begin : g_we
    assign buf_we[gi] = push && (wr_idx == 1'(gi));
  end

  // Store the returning RAM word and its last tag in the tail slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_reg[i] <= '0;
      end
      buf_last_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (buf_we[i]) begin
          buf_data_reg[i] <= bus.rd_data;
          buf_last_reg[i] <= inflight_last_reg;
        end
      end
    end
  end

  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  // Track head slot and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      head_reg  <= head_reg ^ pop;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  // The head entry is only rewritten by a pop, so data and last stay put
  // while the sink stalls.
  assign bus.out_data  = buf_data_reg[head_reg];
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_last  = (count_reg != 2'd0) && head_last;
  assign bus.cmd_ready = cmd_ready_int;
  assign bus.busy      = busy_int;

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 18, giving the data word width.
REQ-002 SHALL have parameter ADDRWIDTH, default 5, giving the RAM address width (depth 2^ADDRWIDTH).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit, asserting a read command.
REQ-006 SHALL have port cmd_ready, output, 1 bit, indicating a command is accepted.
REQ-007 SHALL have port cmd_addr, input, ADDRWIDTH bits, the start address.
REQ-008 SHALL have port cmd_len, input, ADDRWIDTH+1 bits, the word count (0..2^ADDRWIDTH).
REQ-009 SHALL have port rd_addr, output, ADDRWIDTH bits, the read address to the synchronous RAM.
REQ-010 SHALL have port rd_data, input, DATAWIDTH bits, the RAM data, valid one clk after rd_addr is presented.
REQ-011 SHALL have port out_data, output, DATAWIDTH bits, the stream data.
REQ-012 SHALL have port out_valid, output, 1 bit, the stream valid.
REQ-013 SHALL have port out_ready, input, 1 bit, the stream backpressure.
REQ-014 SHALL have port out_last, output, 1 bit, marking the final word of a command.
REQ-015 SHALL have port busy, output, 1 bit, high while a command is in progress.

Function
REQ-016 SHALL implement states IDLE, RUN and DRAIN.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a cycle where cmd_valid && cmd_ready.
REQ-018 SHALL handle a command with cmd_len=0 by staying in IDLE, emitting no words, and keeping cmd_ready high.
REQ-019 SHALL move IDLE->RUN on a command with cmd_len>0, latching the next address = cmd_addr and the remaining issue count = cmd_len.
REQ-020 SHALL issue one read per cycle in RUN by driving rd_addr and capturing rd_data into the output buffer on the following cycle.
REQ-021 SHALL issue a read only when (buffer occupancy + reads in flight) < 2.
REQ-022 SHALL hold rd_addr at its last value when not issuing.
REQ-023 SHALL increment the address modulo 2^ADDRWIDTH after each issued read, wrapping from 2^ADDRWIDTH-1 to 0.
REQ-024 SHALL move RUN->DRAIN in the cycle the last read is issued.
REQ-025 SHALL move DRAIN->IDLE in the cycle the word tagged last is accepted (out_valid && out_ready).
REQ-026 SHALL provide a 2-entry FIFO output buffer; out_data/out_valid/out_last reflect the head entry.
REQ-027 SHALL accept simultaneous capture and pop in the same cycle without loss or duplication.
REQ-028 SHALL not change out_data or out_last while out_valid=1 and out_ready=0.
REQ-029 SHALL assert out_last only on the word from the final issued read of the command.
REQ-030 SHALL sustain 1 word/clk throughput when out_ready is held high; first out_valid occurs 2 clk after command acceptance.
REQ-031 SHALL drive busy=1 in RUN and DRAIN and busy=0 in IDLE.
REQ-032 SHALL ignore cmd_valid while busy.

Reset
REQ-033 SHALL, on reset=1 at a clk edge, go to IDLE, empty the buffer, discard in-flight reads, and abort any command mid-operation without emitting further words.
REQ-034 SHALL have these outputs after reset: out_valid=0, out_last=0, busy=0, cmd_ready=1, rd_addr=0, out_data=0.

Verification
REQ-035 SHALL cover: RAM[i]=i+100, cmd addr=3 len=4, out_ready=1 -> out_data 103,104,105,106 on consecutive clks, out_last only on 106, busy falls the next clk.
REQ-036 SHALL cover: ADDRWIDTH=5, cmd addr=30 len=4 -> rd_addr sequence 30,31,0,1; data from RAM[30],[31],[0],[1].
REQ-037 SHALL cover: len=6 with out_ready toggling randomly (and held low 10 clks) -> exactly 6 words in order, each stable while stalled, no drops or duplicates.
REQ-038 SHALL cover: cmd len=0 -> no out_valid, busy stays 0, cmd_ready stays 1.
REQ-039 SHALL cover: reset asserted after the 2nd word of a len=8 command -> next clk out_valid=0, busy=0, cmd_ready=1; a new len=2 command then yields exactly 2 words.
REQ-040 SHALL cover: len=32 (full depth) from addr=0 -> 32 words, out_last on RAM[31], and cmd_valid pulsed during busy is ignored.
